// File: rtl/pipe_hazard_sb.sv
// Decode-stage hazard unit: per-operand forwarding selects, load-use/multi-cycle stall, MC scoreboard.
// Latency: selects, nostall and mc_wb are combinational from registered state plus current id_* inputs.
// Backpressure: nostall=0 holds the decode instruction; hold freezes all tracked state and suppresses mc_wb.
module pipe_hazard_sb #(
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 2,
  parameter int MC_LAT   = 8,
  localparam int FW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          hold,
  input  logic          id_valid,
  input  logic [4:0]    id_rs,
  input  logic [4:0]    id_rt,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic          id_wreg,
  input  logic          id_load,
  input  logic          id_mc,
  input  logic [4:0]    id_rn,
  output logic [FW-1:0] fwda,
  output logic [FW-1:0] fwdb,
  output logic          nostall,
  output logic          mc_busy,
  output logic          mc_wb,
  output logic [4:0]    mc_wb_rn
);

  // One in-flight instruction as seen by the hazard logic.
  typedef struct packed {
    logic       v;
    logic       wreg;
    logic       load;
    logic [4:0] rn;
  } stage_rec_t;

  stage_rec_t stg [1:DEPTH];

  logic       issue;
  logic       mc_issue;
  logic       lu_a;
  logic       lu_b;
  logic       mc_stall;
  logic       busy;
  logic [7:0] cnt;
  logic [4:0] mc_rn;

  assign issue    = id_valid & nostall & ~hold;
  assign mc_issue = issue & id_mc;

  // Shift the stage records one step per unfrozen cycle; stage 1 takes the issuing instruction or a bubble.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int k = 1; k <= DEPTH; k++) begin
        stg[k] <= '0;
      end
    end else if (!hold) begin
      // MC results return through the scoreboard, not the pipeline, so they never forward from a stage.
      stg[1].v    <= issue;
      stg[1].wreg <= issue & id_wreg & ~id_mc;
      stg[1].load <= issue & id_load;
      stg[1].rn   <= issue ? id_rn : 5'd0;
      for (int k = 2; k <= DEPTH; k++) begin
        stg[k] <= stg[k-1];
      end
    end
  end

  // Operand A: youngest matching producer wins; flag a load that is not yet forwardable.
  always_comb begin
    fwda = '0;
    lu_a = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (id_use_rs && stg[k].v && stg[k].wreg && (stg[k].rn != 5'd0) && (stg[k].rn == id_rs)) begin
        fwda = FW'(k);
        lu_a = stg[k].load && (k < LOAD_LAT);
      end
    end
  end

  // Operand B: same priority search against rt.
  always_comb begin
    fwdb = '0;
    lu_b = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (id_use_rt && stg[k].v && stg[k].wreg && (stg[k].rn != 5'd0) && (stg[k].rn == id_rt)) begin
        fwdb = FW'(k);
        lu_b = stg[k].load && (k < LOAD_LAT);
      end
    end
  end

  // Multi-cycle hazards while the unit is occupied: structural, RAW on its destination, WAW on its destination.
  always_comb begin
    mc_stall = 1'b0;
    if (busy) begin
      if (id_mc) begin
        mc_stall = 1'b1;
      end
      if (id_use_rs && (mc_rn != 5'd0) && (id_rs == mc_rn)) begin
        mc_stall = 1'b1;
      end
      if (id_use_rt && (mc_rn != 5'd0) && (id_rt == mc_rn)) begin
        mc_stall = 1'b1;
      end
      if (id_wreg && (mc_rn != 5'd0) && (id_rn == mc_rn)) begin
        mc_stall = 1'b1;
      end
    end
  end

  assign nostall = ~id_valid | ~(lu_a | lu_b | mc_stall);

  // Scoreboard: load the countdown on MC issue, count down while occupied, release on the write-back edge.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      busy  <= 1'b0;
      cnt   <= 8'd0;
      mc_rn <= 5'd0;
    end else if (!hold) begin
      if (mc_issue) begin
        busy  <= 1'b1;
        cnt   <= 8'(MC_LAT);
        mc_rn <= id_rn;
      end else if (busy) begin
        cnt <= cnt - 8'd1;
        if (cnt == 8'd1) begin
          busy <= 1'b0;
        end
      end
    end
  end

  assign mc_busy  = busy;
  assign mc_wb    = busy & (cnt == 8'd1) & ~hold;
  assign mc_wb_rn = mc_rn;

endmodule
